// File: rtl/resp_signature_checker.sv
//------------------------------------------------------------------------------
// resp_signature_checker
//
// Purpose:
//   Checks one exhaustive sweep of a single-output combinational block. The
//   block sees stimulus values 0 .. 2^NIN-1 in ascending order. Each accepted
//   stim/resp pair is compared against a golden truth table. Mismatches are
//   counted, the first failing vector is recorded, any out-of-order stimulus
//   is flagged, and every pair is folded into a 16-bit MISR signature.
//
// Parameters:
//   NIN    - stimulus width; one sweep is 2^NIN vectors (NIN+1 <= 16)
//   GOLDEN - bit i is the expected response to stimulus value i
//   SEED   - MISR start value
//
// Ports:
//   CK               in   clock, all state updates on the rising edge
//   reset            in   asynchronous active-low reset
//   start            in   begin a new sweep (ignored while a sweep runs)
//   stim_valid       in   stim/resp pair present this cycle
//   stim [NIN-1:0]   in   stimulus vector applied to the device under test
//   resp             in   device-under-test response for stim
//   busy             out  sweep in progress
//   done             out  sweep complete, results valid
//   pass             out  done with zero mismatches and no sequence error
//   mismatch_cnt     out  number of vectors whose resp differs from GOLDEN
//   seq_err          out  sticky: a stim arrived out of ascending order
//   first_fail_vec   out  stim value of the first mismatch
//   first_fail_valid out  first_fail_vec holds a captured value
//   signature [15:0] out  MISR compaction of all accepted pairs
//------------------------------------------------------------------------------
module resp_signature_checker #(
    parameter int                  NIN    = 3,
    parameter logic [(1<<NIN)-1:0] GOLDEN = 8'b1001_0110,
    parameter logic [15:0]         SEED   = 16'hFFFF
) (
    input  logic           CK,
    input  logic           reset,
    input  logic           start,
    input  logic           stim_valid,
    input  logic [NIN-1:0] stim,
    input  logic           resp,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [NIN:0]   mismatch_cnt,
    output logic           seq_err,
    output logic [NIN-1:0] first_fail_vec,
    output logic           first_fail_valid,
    output logic [15:0]    signature
);

    localparam logic [15:0] POLY = 16'h1021;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state, state_next;
    logic [NIN-1:0] exp_idx;

    logic        accept;
    logic        start_ok;
    logic        last_pair;
    logic        miss;
    logic [15:0] sig_next;

    // A pair only counts while sweeping; start is only honoured outside SWEEP,
    // so the cycle that accepts start can never also accept a pair.
    assign accept    = (state == SWEEP) && stim_valid;
    assign start_ok  = start && (state != SWEEP);
    // The expected index advances once per accepted pair, so the final pair
    // of the sweep is the one accepted while it sits at all-ones.
    assign last_pair = accept && (exp_idx == '1);
    assign miss      = (resp != GOLDEN[stim]);

    assign sig_next = {signature[14:0], 1'b0}
                    ^ (signature[15] ? POLY : 16'h0000)
                    ^ 16'({stim, resp});

    //--------------------------------------------------------------------------
    // FSM state register
    //--------------------------------------------------------------------------
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values, independent of block order.
            state <= state_next;
        end
    end

    //--------------------------------------------------------------------------
    // FSM next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns state_next; without it a
        // missed branch would infer a latch.
        state_next = state;
        unique case (state)
            IDLE:    if (start_ok)  state_next = SWEEP;
            SWEEP:   if (last_pair) state_next = DONE;
            DONE:    if (start_ok)  state_next = SWEEP;
            default: state_next = IDLE;
        endcase
    end

    //--------------------------------------------------------------------------
    // Result datapath: cleared on start, updated per accepted pair, and left
    // untouched otherwise so results hold steady through DONE.
    //--------------------------------------------------------------------------
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            exp_idx          <= '0;
            mismatch_cnt     <= '0;
            seq_err          <= 1'b0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            signature        <= SEED;
        end else if (start_ok) begin
            exp_idx          <= '0;
            mismatch_cnt     <= '0;
            seq_err          <= 1'b0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            signature        <= SEED;
        end else if (accept) begin
            exp_idx   <= exp_idx + NIN'(1);
            signature <= sig_next;
            if (stim != exp_idx) begin
                seq_err <= 1'b1;
            end
            if (miss) begin
                // 2^NIN mismatches fit in NIN+1 bits, so no saturation.
                mismatch_cnt <= mismatch_cnt + (NIN+1)'(1);
                if (!first_fail_valid) begin
                    first_fail_vec   <= stim;
                    first_fail_valid <= 1'b1;
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Status outputs
    //--------------------------------------------------------------------------
    assign busy = (state == SWEEP);
    assign done = (state == DONE);
    assign pass = done && (mismatch_cnt == '0) && !seq_err;

endmodule

// File: tb/tb_resp_signature_checker.sv
//------------------------------------------------------------------------------
// tb_resp_signature_checker
//
// Directed bench for resp_signature_checker with default parameters
// (NIN=3, GOLDEN=8'b1001_0110, SEED=16'hFFFF). Inputs change on the falling
// edge and outputs are sampled on the falling edge, away from the rising edge.
//------------------------------------------------------------------------------
module tb_resp_signature_checker;

    localparam int          NIN    = 3;
    localparam logic [7:0]  GOLDEN = 8'b1001_0110;
    localparam logic [15:0] SEED   = 16'hFFFF;

    logic           CK;
    logic           reset;
    logic           start;
    logic           stim_valid;
    logic [NIN-1:0] stim;
    logic           resp;
    logic           busy;
    logic           done;
    logic           pass;
    logic [NIN:0]   mismatch_cnt;
    logic           seq_err;
    logic [NIN-1:0] first_fail_vec;
    logic           first_fail_valid;
    logic [15:0]    signature;

    int errors = 0;
    int checks = 0;

    // Stimulus table used by run_pairs and the signature reference.
    logic [NIN-1:0] stim_tab [8];
    logic           resp_tab [8];

    // Signature of the undisturbed golden sweep, reused by later scenarios.
    logic [15:0] gold_sig;

    resp_signature_checker #(
        .NIN    (NIN),
        .GOLDEN (GOLDEN),
        .SEED   (SEED)
    ) dut (
        .CK               (CK),
        .reset            (reset),
        .start            (start),
        .stim_valid       (stim_valid),
        .stim             (stim),
        .resp             (resp),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .mismatch_cnt     (mismatch_cnt),
        .seq_err          (seq_err),
        .first_fail_vec   (first_fail_vec),
        .first_fail_valid (first_fail_valid),
        .signature        (signature)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Reference MISR over the first n entries of the stimulus table.
    function automatic logic [15:0] sig_ref(input int n);
        logic [15:0] s;
        logic        fb;
        s = SEED;
        for (int i = 0; i < n; i++) begin
            fb = s[15];
            s  = s << 1;
            if (fb) s = s ^ 16'h1021;
            s = s ^ {12'h000, stim_tab[i], resp_tab[i]};
        end
        return s;
    endfunction

    // Load the table with the golden ascending sweep.
    task automatic load_golden();
        for (int i = 0; i < 8; i++) begin
            stim_tab[i] = 3'(i);
            resp_tab[i] = GOLDEN[i];
        end
    endtask

    task automatic pulse_start();
        @(negedge CK);
        start = 1'b1;
        @(negedge CK);
        start = 1'b0;
    endtask

    // Drive table entries [first, first+n) back to back, one per cycle.
    // A start pulse is overlaid on entry start_at (negative: none).
    task automatic run_pairs(input int first, input int n, input int start_at);
        for (int i = first; i < first + n; i++) begin
            @(negedge CK);
            stim_valid = 1'b1;
            stim       = stim_tab[i];
            resp       = resp_tab[i];
            start      = (i == start_at);
        end
        @(negedge CK);
        stim_valid = 1'b0;
        start      = 1'b0;
    endtask

    //--------------------------------------------------------------------------
    task automatic test_reset();
        reset      = 1'b0;
        start      = 1'b0;
        stim_valid = 1'b0;
        stim       = '0;
        resp       = 1'b0;
        repeat (2) @(negedge CK);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b want 0", pass); end
        checks++; if (mismatch_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", mismatch_cnt); end
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq_err: got %b want 0", seq_err); end
        checks++; if (first_fail_valid !== 1'b0) begin errors++; $display("FAIL reset_ffv: got %b want 0", first_fail_valid); end
        checks++; if (first_fail_vec !== 3'd0) begin errors++; $display("FAIL reset_ffvec: got %0d want 0", first_fail_vec); end
        checks++; if (signature !== 16'hFFFF) begin errors++; $display("FAIL reset_sig: got %h want ffff", signature); end
        reset = 1'b1;
        @(negedge CK);
    endtask

    // One pair stim=000 resp=0 from SEED: FFFF<<1 = FFFE, ^1021 = EFDF.
    task automatic test_single_pair();
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        stim_tab[0] = 3'd0;
        resp_tab[0] = 1'b0;
        run_pairs(0, 1, -1);
        checks++; if (signature !== 16'hEFDF) begin errors++; $display("FAIL single_sig: got %h want efdf", signature); end
        checks++; if (mismatch_cnt !== 4'd0) begin errors++; $display("FAIL single_cnt: got %0d want 0", mismatch_cnt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_still_busy: got %b want 1", busy); end
        // Abandon this partial sweep.
        @(negedge CK); reset = 1'b0;
        @(negedge CK); reset = 1'b1;
    endtask

    task automatic test_golden();
        load_golden();
        gold_sig = sig_ref(8);
        pulse_start();
        run_pairs(0, 7, -1);
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL golden_after7: got busy=%b done=%b want busy=1 done=0", busy, done); end
        run_pairs(7, 1, -1);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL golden_done: got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL golden_busy: got %b want 0", busy); end
        checks++; if (mismatch_cnt !== 4'd0) begin errors++; $display("FAIL golden_cnt: got %0d want 0", mismatch_cnt); end
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL golden_seq_err: got %b want 0", seq_err); end
        checks++; if (first_fail_valid !== 1'b0) begin errors++; $display("FAIL golden_ffv: got %b want 0", first_fail_valid); end
        checks++; if (pass !== 1'b1) begin errors++; $display("FAIL golden_pass: got %b want 1", pass); end
        checks++; if (signature !== gold_sig) begin errors++; $display("FAIL golden_sig: got %h want %h", signature, gold_sig); end
        // Results hold in DONE.
        repeat (3) @(negedge CK);
        checks++; if (done !== 1'b1 || pass !== 1'b1 || signature !== gold_sig) begin errors++; $display("FAIL golden_hold: got done=%b pass=%b sig=%h want 1 1 %h", done, pass, signature, gold_sig); end
    endtask

    // resp inverted on stim 3 and 6; restarts from DONE.
    task automatic test_mismatch();
        logic [15:0] exp_sig;
        load_golden();
        resp_tab[3] = ~GOLDEN[3];
        resp_tab[6] = ~GOLDEN[6];
        exp_sig = sig_ref(8);
        pulse_start();
        checks++; if (done !== 1'b0 || busy !== 1'b1 || mismatch_cnt !== 4'd0) begin errors++; $display("FAIL mm_restart: got done=%b busy=%b cnt=%0d want 0 1 0", done, busy, mismatch_cnt); end
        run_pairs(0, 8, -1);
        checks++; if (mismatch_cnt !== 4'd2) begin errors++; $display("FAIL mm_cnt: got %0d want 2", mismatch_cnt); end
        checks++; if (first_fail_vec !== 3'd3) begin errors++; $display("FAIL mm_ffvec: got %0d want 3", first_fail_vec); end
        checks++; if (first_fail_valid !== 1'b1) begin errors++; $display("FAIL mm_ffv: got %b want 1", first_fail_valid); end
        checks++; if (pass !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL mm_pass: got pass=%b done=%b want 0 1", pass, done); end
        checks++; if (signature !== exp_sig) begin errors++; $display("FAIL mm_sig: got %h want %h", signature, exp_sig); end
    endtask

    // Order 0,1,3,2,4..7 with correct responses.
    task automatic test_seq_err();
        logic [15:0] exp_sig;
        load_golden();
        stim_tab[2] = 3'd3; resp_tab[2] = GOLDEN[3];
        stim_tab[3] = 3'd2; resp_tab[3] = GOLDEN[2];
        exp_sig = sig_ref(8);
        pulse_start();
        checks++; if (first_fail_valid !== 1'b0) begin errors++; $display("FAIL seq_clear_ffv: got %b want 0", first_fail_valid); end
        run_pairs(0, 8, -1);
        checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_flag: got %b want 1", seq_err); end
        checks++; if (mismatch_cnt !== 4'd0) begin errors++; $display("FAIL seq_cnt: got %0d want 0", mismatch_cnt); end
        checks++; if (pass !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL seq_pass: got pass=%b done=%b want 0 1", pass, done); end
        checks++; if (signature !== exp_sig) begin errors++; $display("FAIL seq_sig: got %h want %h", signature, exp_sig); end
    endtask

    // Reset after 4 pairs (one mismatch on stim 1), then a fresh golden sweep
    // with start held across the reset release.
    task automatic test_reset_mid();
        load_golden();
        resp_tab[1] = ~GOLDEN[1];
        pulse_start();
        run_pairs(0, 4, -1);
        checks++; if (mismatch_cnt !== 4'd1 || first_fail_valid !== 1'b1) begin errors++; $display("FAIL rmid_partial: got cnt=%0d ffv=%b want 1 1", mismatch_cnt, first_fail_valid); end
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || mismatch_cnt !== 4'd0 || first_fail_valid !== 1'b0 || first_fail_vec !== 3'd0 || seq_err !== 1'b0 || signature !== SEED) begin
            errors++; $display("FAIL rmid_async: got busy=%b cnt=%0d ffv=%b ffvec=%0d seq=%b sig=%h want 0 0 0 0 0 ffff", busy, mismatch_cnt, first_fail_valid, first_fail_vec, seq_err, signature);
        end
        start = 1'b1;
        @(negedge CK);
        reset = 1'b1;
        @(negedge CK);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_first_start: got busy=%b want 1", busy); end
        load_golden();
        run_pairs(0, 8, -1);
        checks++; if (done !== 1'b1 || pass !== 1'b1 || mismatch_cnt !== 4'd0 || seq_err !== 1'b0 || first_fail_valid !== 1'b0 || signature !== gold_sig) begin
            errors++; $display("FAIL rmid_sweep: got done=%b pass=%b cnt=%0d seq=%b ffv=%b sig=%h want 1 1 0 0 0 %h", done, pass, mismatch_cnt, seq_err, first_fail_valid, signature, gold_sig);
        end
    endtask

    // start overlaid on a mid-sweep pair; a wrong-response pair offered in DONE.
    task automatic test_disturb();
        load_golden();
        pulse_start();
        run_pairs(0, 8, 4);
        checks++; if (done !== 1'b1 || pass !== 1'b1 || mismatch_cnt !== 4'd0 || signature !== gold_sig) begin
            errors++; $display("FAIL dist_mid_start: got done=%b pass=%b cnt=%0d sig=%h want 1 1 0 %h", done, pass, mismatch_cnt, signature, gold_sig);
        end
        @(negedge CK);
        stim_valid = 1'b1;
        stim       = 3'd0;
        resp       = ~GOLDEN[0];
        @(negedge CK);
        stim_valid = 1'b0;
        checks++; if (done !== 1'b1 || pass !== 1'b1 || mismatch_cnt !== 4'd0 || first_fail_valid !== 1'b0 || signature !== gold_sig) begin
            errors++; $display("FAIL dist_done_valid: got done=%b pass=%b cnt=%0d ffv=%b sig=%h want 1 1 0 0 %h", done, pass, mismatch_cnt, first_fail_valid, signature, gold_sig);
        end
    endtask

    initial begin
        test_reset();
        test_single_pair();
        test_golden();
        test_mismatch();
        test_seq_err();
        test_reset_mid();
        test_disturb();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
